// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: registered one-hot grant and binary mux select, with a turnaround cycle between owners.
// Optional ownership watchdog enabled by defining ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | bus free; arbitrate among requests starting at ptr
// OWN   | one master holds the bus until it drops req (or the watchdog fires)
// TURN  | one turnaround cycle with no grant before the next arbitration
module bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SEL_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 bus_busy,
  output logic                 timeout
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || NUM_REQ > (2 ** SEL_WIDTH) || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("bus_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t               state, state_nx;
  logic [SEL_WIDTH-1:0] ptr, ptr_nx;
  logic [SEL_WIDTH-1:0] win;
  logic [SEL_WIDTH:0]   idx;
  logic                 found;
  logic [NUM_REQ-1:0]   grant_nx;
  logic [SEL_WIDTH-1:0] sel_nx;
  logic                 busy_nx;
  logic                 owner_req;
  logic                 revoke;
  logic                 release_own;

  // In OWN exactly one grant bit is set, so this is req[owner].
  assign owner_req   = |(req & grant);
  assign release_own = (state == OWN) && (!owner_req || revoke);

  // Rotating scan: first requester at or after ptr, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (SEL_WIDTH+1)'(i);
      if (idx >= (SEL_WIDTH+1)'(NUM_REQ)) idx = idx - (SEL_WIDTH+1)'(NUM_REQ);
      if (!found && req[idx[SEL_WIDTH-1:0]]) begin
        found = 1'b1;
        win   = idx[SEL_WIDTH-1:0];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  assign revoke = (state == OWN) && owner_req && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= (state == OWN) ? cnt + 1'b1 : '0;
      timeout <= revoke;
    end
  end
`else
  assign revoke  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      bus_busy <= 1'b0;
      ptr      <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      sel      <= sel_nx;
      bus_busy <= busy_nx;
      ptr      <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = OWN;
      OWN:     if (release_own) state_nx = TURN;
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // sel is left untouched on release so the mux keeps the last owner.
  always_comb begin
    grant_nx = grant;
    sel_nx   = sel;
    busy_nx  = bus_busy;
    ptr_nx   = ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nx = NUM_REQ'(1) << win;
          sel_nx   = win;
          busy_nx  = 1'b1;
        end
      end
      OWN: begin
        if (release_own) begin
          grant_nx = '0;
          busy_nx  = 1'b0;
          ptr_nx   = (sel == SEL_WIDTH'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
